// File: rtl/color_convert_2_sum_clamp.sv
// Colour-conversion back end: sums three signed products, rounds, shifts, offsets
// chroma, clamps to a byte. Two-stage valid/ready pipeline plus a clamp-event counter.
module color_convert_2_sum_clamp #(
    parameter int PROD_WIDTH    = 18,
    parameter int FRAC_BITS     = 8,
    parameter int CHROMA_OFFSET = 128,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PROD_WIDTH-1:0] s_prod0,
    input  logic [PROD_WIDTH-1:0] s_prod1,
    input  logic [PROD_WIDTH-1:0] s_prod2,
    input  logic [1:0]            s_chan,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [7:0]            m_data,
    output logic [1:0]            m_chan,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  clamp_cnt,
    input  logic                  cnt_clear
);
    localparam int SW = PROD_WIDTH + 2;
    localparam int RW = SW + 2;
    localparam logic signed [RW-1:0] ROUND_C  = RW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [RW-1:0] OFFSET_C = RW'(CHROMA_OFFSET);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // Handshake: a beat moves across an interface on a rising edge where valid and
    // ready are both high; output payload is held while m_valid=1 and m_ready=0.
    logic                 r_v1;
    logic signed [SW-1:0] r_sum;
    logic [1:0]           r_chan1;
    logic                 r_last1;
    logic                 r_v2;
    logic                 r_clamp2;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic                 w_s1_load;
    logic                 w_s2_load;
    logic signed [SW-1:0] w_sum;
    logic signed [RW-1:0] w_rnd;
    logic signed [RW-1:0] w_shift;
    logic signed [RW-1:0] w_res;
    logic                 w_chroma;
    logic                 w_lo;
    logic                 w_hi;
    logic [7:0]           w_byte;
    logic                 w_clamp;

    assign w_s2_load = r_v1 & (~r_v2 | m_ready);
    assign w_s1_load = s_valid & (~r_v1 | w_s2_load);
    assign s_ready   = ~r_v1 | w_s2_load;
    assign m_valid   = r_v2;
    assign clamp_cnt = r_cnt;

    assign w_sum = $signed({{2{s_prod0[PROD_WIDTH-1]}}, s_prod0})
                 + $signed({{2{s_prod1[PROD_WIDTH-1]}}, s_prod1})
                 + $signed({{2{s_prod2[PROD_WIDTH-1]}}, s_prod2});

    // Two guard bits above the sum absorb the rounding constant and the chroma offset.
    assign w_rnd    = $signed({{2{r_sum[SW-1]}}, r_sum}) + ROUND_C;
    assign w_shift  = w_rnd >>> FRAC_BITS;
    assign w_chroma = (r_chan1 == 2'd1) || (r_chan1 == 2'd2);
    assign w_res    = w_shift + (w_chroma ? OFFSET_C : '0);

    always_comb begin
        w_lo    = w_res[RW-1];
        w_hi    = ~w_res[RW-1] & (|w_res[RW-2:8]);
        w_clamp = w_lo | w_hi;
        w_byte  = w_res[7:0];
        if (w_lo) begin
            w_byte = 8'h00;
        end else if (w_hi) begin
            w_byte = 8'hFF;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_v1    <= 1'b0;
            r_sum   <= '0;
            r_chan1 <= 2'd0;
            r_last1 <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_v1    <= 1'b1;
                r_sum   <= w_sum;
                r_chan1 <= s_chan;
                r_last1 <= s_last;
            end else if (w_s2_load) begin
                r_v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_v2     <= 1'b0;
            r_clamp2 <= 1'b0;
            m_data   <= 8'h00;
            m_chan   <= 2'd0;
            m_last   <= 1'b0;
        end else begin
            if (w_s2_load) begin
                r_v2     <= 1'b1;
                r_clamp2 <= w_clamp;
                m_data   <= w_byte;
                m_chan   <= r_chan1;
                m_last   <= r_last1;
            end else if (m_ready) begin
                r_v2 <= 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle clamped transfer; the count sticks at all-ones.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clear) begin
            r_cnt <= '0;
        end else if (r_v2 && m_ready && r_clamp2 && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_color_convert_2_sum_clamp.sv
// Bench for color_convert_2_sum_clamp: directed vectors plus randomized streaming,
// checked every cycle against an arithmetic reference model and a scoreboard queue.
module tb_color_convert_2_sum_clamp;
  localparam int PW  = 18;
  localparam int FB  = 8;
  localparam int OFF = 128;
  localparam int CW  = 4;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic signed [PW-1:0] s_prod0 = '0;
  logic signed [PW-1:0] s_prod1 = '0;
  logic signed [PW-1:0] s_prod2 = '0;
  logic [1:0]           s_chan = 2'd0;
  logic                 s_last = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [7:0]           m_data;
  logic [1:0]           m_chan;
  logic                 m_last;
  logic [CW-1:0]        clamp_cnt;
  logic                 cnt_clear = 1'b0;

  color_convert_2_sum_clamp #(
    .PROD_WIDTH(PW), .FRAC_BITS(FB), .CHROMA_OFFSET(OFF), .CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_prod0(s_prod0), .s_prod1(s_prod1), .s_prod2(s_prod2),
    .s_chan(s_chan), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last),
    .clamp_cnt(clamp_cnt), .cnt_clear(cnt_clear)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [11:0] exp_q[$];
  int          exp_cnt = 0;
  int          out_xfers = 0;
  int          in_xfers = 0;
  bit          prev_hold = 0;
  logic [10:0] prev_out = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: {last, chan[1:0], clamped, data[7:0]}
  function automatic logic [11:0] model(input longint p0, input longint p1, input longint p2,
                                        input logic [1:0] ch, input logic last);
    longint r;
    logic [7:0] d;
    logic c;
    r = p0 + p1 + p2;
    r = (r + (64'sd1 <<< (FB - 1))) >>> FB;
    if (ch == 2'd1 || ch == 2'd2) r = r + OFF;
    if (r < 0) begin d = 8'd0; c = 1'b1; end
    else if (r > 255) begin d = 8'd255; c = 1'b1; end
    else begin d = r[7:0]; c = 1'b0; end
    return {last, ch, c, d};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge ap_clk) begin
    logic [11:0] e;
    logic        clamped;
    logic        xfer;
    if (ap_rst_n) begin
      clamped = 1'b0;
      xfer = m_valid && m_ready;
      check("clamp_cnt", clamp_cnt, exp_cnt);
      if (prev_hold) begin
        check("hold_valid", m_valid, 1);
        check("hold_payload", {m_last, m_chan, m_data}, prev_out);
      end
      if (xfer) begin
        out_xfers++;
        if (exp_q.size() == 0) begin
          check("out_without_input", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[7:0]);
          check("m_chan", m_chan, e[10:9]);
          check("m_last", m_last, e[11]);
          clamped = e[8];
        end
      end
      if (cnt_clear) exp_cnt = 0;
      else if (xfer && clamped && exp_cnt < (1 << CW) - 1) exp_cnt++;
      if (s_valid && s_ready) begin
        in_xfers++;
        exp_q.push_back(model(longint'(s_prod0), longint'(s_prod1), longint'(s_prod2),
                              s_chan, s_last));
      end
      prev_hold = m_valid && !m_ready;
      prev_out = {m_last, m_chan, m_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_beat(input longint p0, input longint p1, input longint p2,
                          input logic [1:0] ch, input logic last);
    s_prod0 = PW'(p0);
    s_prod1 = PW'(p1);
    s_prod2 = PW'(p2);
    s_chan = ch;
    s_last = last;
  endtask

  task automatic rand_beat();
    set_beat(longint'($urandom_range(0, 70000)) - 35000,
             longint'($urandom_range(0, 70000)) - 35000,
             longint'($urandom_range(0, 70000)) - 35000,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input longint p0, input longint p1, input longint p2,
                      input logic [1:0] ch, input logic last);
    int t;
    set_beat(p0, p1, p2, ch, last);
    s_valid = 1'b1;
    t = 0;
    @(negedge ap_clk);
    while (!s_ready && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    if (!s_ready) check("send_timeout", s_ready, 1);
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Pipeline must be empty and m_ready=1; leaves time at the cycle m_valid is first seen.
  task automatic latency_beat(input string name, input longint p0, input longint p1,
                              input longint p2, input logic [1:0] ch, input logic last);
    int lat;
    set_beat(p0, p1, p2, ch, last);
    s_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    check(name, lat, 2);
  endtask

  task automatic drain();
    int t;
    m_ready = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      @(posedge ap_clk);
      #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [11:0] e;
    int base_in, mark_out, sent, cyc, t;
    bit acc;

    // Model pins from hand-worked vectors
    e = model(19635, 38250, 7395, 2'd0, 1'b0);
    check("pin_white_y", e, 12'h0FF);
    e = model(-10965, -21675, 32640, 2'd1, 1'b0);
    check("pin_white_cb", e, {1'b0, 2'd1, 1'b0, 8'd128});
    e = model(70000, 0, 0, 2'd0, 1'b0);
    check("pin_clamp_hi", e, {1'b0, 2'd0, 1'b1, 8'd255});
    e = model(-1000, 0, 0, 2'd0, 1'b0);
    check("pin_clamp_lo", e, {1'b0, 2'd0, 1'b1, 8'd0});
    e = model(-2560, 0, 0, 2'd2, 1'b1);
    check("pin_cr_neg", e, {1'b1, 2'd2, 1'b0, 8'd118});

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_clamp_cnt", clamp_cnt, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_chan", m_chan, 0);
    check("rst_m_last", m_last, 0);
    ap_rst_n = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 1);
    @(posedge ap_clk);
    #1;
    m_ready = 1'b1;

    // White Y / Cb / Cr
    latency_beat("lat_white_y", 19635, 38250, 7395, 2'd0, 1'b0);
    check("white_y_data", m_data, 255);
    @(posedge ap_clk);
    #1;
    check("white_y_noclamp", clamp_cnt, 0);
    latency_beat("lat_white_cb", -10965, -21675, 32640, 2'd1, 1'b0);
    check("white_cb_data", m_data, 128);
    @(posedge ap_clk);
    #1;
    latency_beat("lat_white_cr", -10965, -21675, 32640, 2'd2, 1'b0);
    check("white_cr_data", m_data, 128);
    check("white_cr_chan", m_chan, 2);
    @(posedge ap_clk);
    #1;

    // Clamp events and clear priority
    latency_beat("lat_clamp_hi", 70000, 0, 0, 2'd0, 1'b0);
    check("clamp_hi_data", m_data, 255);
    @(posedge ap_clk);
    #1;
    check("clamp_cnt_1", clamp_cnt, 1);
    latency_beat("lat_clamp_lo", -1000, 0, 0, 2'd0, 1'b0);
    check("clamp_lo_data", m_data, 0);
    @(posedge ap_clk);
    #1;
    check("clamp_cnt_2", clamp_cnt, 2);
    m_ready = 1'b0;
    send(70000, 0, 0, 2'd0, 1'b0);
    t = 0;
    while (!m_valid && t < 20) begin
      @(posedge ap_clk);
      #1;
      t++;
    end
    check("clear_wait_valid", m_valid, 1);
    cnt_clear = 1'b1;
    m_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    cnt_clear = 1'b0;
    check("clear_priority", clamp_cnt, 0);

    // Backpressure: three back-to-back beats, output stalled
    m_ready = 1'b0;
    mark_out = out_xfers;
    fork
      begin
        send(25600, 0, 0, 2'd0, 1'b0);
        send(0, 0, 0, 2'd1, 1'b0);
        send(-2560, 0, 0, 2'd2, 1'b1);
      end
    join_none
    repeat (5) @(posedge ap_clk);
    #1;
    check("bp_s_ready_low", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    check("bp_head_data", m_data, 100);
    m_ready = 1'b1;
    wait fork;
    drain();
    check("bp_out_count", out_xfers - mark_out, 3);

    // Full throughput with both sides held high
    m_ready = 1'b1;
    base_in = in_xfers;
    mark_out = out_xfers;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) mark_out = out_xfers;
      rand_beat();
      s_valid = 1'b1;
      @(posedge ap_clk);
      #1;
    end
    s_valid = 1'b0;
    check("tput_in", in_xfers - base_in, 40);
    check("tput_out", out_xfers - mark_out, 30);
    drain();

    // Random streaming with random valid/ready
    sent = 0;
    cyc = 0;
    while (sent < 64 && cyc < 5000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (!s_valid && $urandom_range(0, 3) != 0) begin
        rand_beat();
        s_valid = 1'b1;
      end
      @(negedge ap_clk);
      acc = s_valid && s_ready;
      @(posedge ap_clk);
      #1;
      cyc++;
      if (acc) begin
        s_valid = 1'b0;
        sent++;
      end
    end
    check("stream_sent", sent, 64);
    drain();

    // Reset with beats in flight
    m_ready = 1'b1;
    send(70000, 0, 0, 2'd0, 1'b0);
    send(70000, 0, 0, 2'd0, 1'b0);
    drain();
    m_ready = 1'b0;
    send(70000, 0, 0, 2'd1, 1'b0);
    send(-70000, 0, 0, 2'd0, 1'b1);
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_clamp_cnt", clamp_cnt, 0);
    check("midrst_m_data", m_data, 0);
    exp_q.delete();
    exp_cnt = 0;
    prev_hold = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    latency_beat("lat_after_reset", 19635, 38250, 7395, 2'd3, 1'b1);
    check("after_reset_data", m_data, 255);
    check("after_reset_chan", m_chan, 3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/color_convert_2_sum_clamp.md
Name: color_convert_2_sum_clamp

Overview:
Downstream stage of the colour-conversion multipliers. Each beat carries the three signed per-channel products for one output component (Y, Cb or Cr). The block sums them, rounds, shifts out the fractional bits, adds the chroma level offset, clamps to 8 bits and emits one byte per beat. It is a 2-stage valid/ready pipeline with full throughput and backpressure. It also keeps a saturating count of clamp events for debug.

Parameters:
PROD_WIDTH, 18, width of each signed product input
FRAC_BITS, 8, fractional bits of the coefficient format; shift amount (must be >= 1)
CHROMA_OFFSET, 128, offset added to the Cb/Cr channels after the shift
CNT_WIDTH, 16, width of the clamp-event counter

Ports:
ap_clk  in  1  clock; all state on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  block accepts the input beat
s_prod0  in  PROD_WIDTH  signed product, term 0
s_prod1  in  PROD_WIDTH  signed product, term 1
s_prod2  in  PROD_WIDTH  signed product, term 2
s_chan  in  2  0=Y, 1=Cb, 2=Cr, 3=reserved (treated as Y)
s_last  in  1  end-of-block marker, passed through unchanged
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts the output beat
m_data  out  8  clamped unsigned component
m_chan  out  2  channel tag, passed through
m_last  out  1  passed-through marker
clamp_cnt  out  CNT_WIDTH  number of beats clamped since reset or clear
cnt_clear  in  1  synchronous clear of clamp_cnt

Behaviour:
- Reset (async assert, sync release): m_valid=0, both stage valids=0, clamp_cnt=0. Reset drives m_data, m_chan and m_last to 0. s_ready reads 1 once ap_rst_n is high. Asserting reset mid-stream drops all in-flight beats.
- Transfer rules: input transfer when s_valid&s_ready; output transfer when m_valid&m_ready. m_data, m_chan and m_last must stay stable while m_valid=1 and m_ready=0.
- Stage 1 (S1):
  - sum = sext(p0)+sext(p1)+sext(p2), computed at PROD_WIDTH+2 bits. Overflow is impossible at this width.
  - Registers sum, chan and last; sets v1.
- Stage 2 (S2):
  - r = (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, using an arithmetic shift (floor toward -inf).
  - For chan 1 or 2, add CHROMA_OFFSET; for chan 0 or 3, add 0.
  - Clamp: r<0 gives 0; r>255 gives 255; otherwise r[7:0].
  - The clamp flag is set when either bound hit.
  - Registers the result into the m_* outputs; v2 drives m_valid.
- Advance rules:
  - S2 loads when v1 and (!v2 or m_ready).
  - S1 loads when s_valid and (!v1 or S2 loads).
  - s_ready = !v1 | S2 loads. A combinational path from m_ready to s_ready is permitted.
- Latency and throughput: exactly 2 cycles from input transfer to m_valid when unstalled. One beat per cycle is sustained with m_ready=1. No beat is dropped, duplicated or reordered under any m_ready pattern.
- Simultaneous load and drain: when S2 drains and reloads in the same cycle, m_valid stays 1 and the new data appears.
- clamp_cnt:
  - Increments by 1 on each output transfer whose beat was clamped.
  - Saturates at all-ones (no wrap).
  - cnt_clear has priority: it sets the count to 0 in that cycle even if a clamped beat transfers.
- Reserved channel: s_chan=3 is processed as Y with no offset. m_chan carries 3.

Test Plan:
- White Y: prods 19635, 38250, 7395 with chan 0 -> sum 65280 -> m_data=255, no clamp (r=255 exactly), clamp_cnt=0, m_valid 2 cycles after accept.
- White Cb: prods -10965, -21675, 32640 with chan 1 -> sum 0 -> r=0, +128 -> m_data=128; same beat with chan 2 -> 128, m_chan=2.
- Clamp: chan 0 sum 70000 -> 273 -> m_data=255, clamp_cnt=1. Then chan 0 sum -1000 -> -4 -> m_data=0, clamp_cnt=2. Then cnt_clear=1 together with another clamped transfer -> clamp_cnt=0.
- Backpressure: 3 beats back-to-back, m_ready=0 for 5 cycles -> s_ready falls after 2 beats are held, the third is held at the input, m_data is stable. Releasing m_ready yields all 3 in order, with s_last preserved on beat 3.
- Streaming: 64 random beats with random s_valid/m_ready -> output matches the reference model, bit-exact and in order. Full throughput is measured when both are held at 1.
- Reset mid-op: ap_rst_n low with 2 beats in flight -> m_valid=0 and clamp_cnt=0 immediately (async). After release, the first new beat emerges 2 cycles after accept.
